imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Upstream of the cpu core. Receives a framed byte stream and writes it as 32-bit words into
//  instruction memory, replacing the static program.mem preload. Holds the cpu in reset until a
//  frame has loaded and its checksum verifies, then releases it so cycle_count starts from 0.
//  Frame: N_lo, N_hi (word count N, 16 bit LE), 4*N data bytes (each word LE), 1 checksum byte.
// PARAMETERS
//  ADDR_WIDTH  8   word-address width of imem; capacity = 2**ADDR_WIDTH words
// PORTS
//  clk           in   1             system clock, single domain
//  reset         in   1             synchronous, active-high
//  start         in   1             1-cycle pulse: begin a new load (ignored while busy)
//  in_valid      in   1             byte-stream valid
//  in_data       in   8             byte-stream data
//  in_ready      out  1             byte-stream ready; byte accepted when in_valid & in_ready
//  mem_we        out  1             imem write strobe (1-cycle pulse)
//  mem_addr      out  ADDR_WIDTH    imem word address
//  mem_wdata     out  32            imem write data
//  cpu_reset     out  1             reset to cpu core, active-high
//  busy          out  1             load in progress
//  done          out  1             sticky: last load passed
//  error         out  1             sticky: last load failed (checksum or overflow)
//  words_loaded  out  ADDR_WIDTH+1  words written in current/last load
// BEHAVIOUR
//  - Reset (any cycle, including mid-load): state IDLE; in_ready=0, mem_we=0, mem_addr=0,
//    mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0. No write after reset.
//  - States: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR. in_ready = 1 only in HDR0/HDR1/DATA/CSUM,
//    decoded combinationally from state. All other outputs are registered.
//  - IDLE/DONE/ERROR + start: go to HDR0. Clear done, error, words_loaded, checksum, byte index.
//    Set busy=1 and cpu_reset=1. start in HDR0..CSUM has no effect.
//  - HDR0: latch N[7:0]. HDR1: latch N[15:8], then:
//    - if N > 2**ADDR_WIDTH, go to ERROR with no writes;
//    - else if N == 0, go to CSUM;
//    - else go to DATA.
//  - DATA: bytes fill word LE (byte0 -> [7:0] ... byte3 -> [31:24]). When byte3 is accepted, the
//    next cycle has mem_we=1, mem_addr=word index, mem_wdata=assembled word. Word index and
//    words_loaded then increment. After word N-1 the state goes to CSUM. in_valid gaps only stall.
//  - Checksum: 8-bit mod-256 sum of every accepted byte (header + data + trailer). In CSUM, if the
//    sum including the trailer == 8'h00, go to DONE: done=1, busy=0, cpu_reset=0. Otherwise go to
//    ERROR: error=1, busy=0, cpu_reset stays 1.
//  - No rollback: words written before an error stay in imem. mem_addr/mem_wdata hold last value.
//  - DONE/ERROR persist until start or reset. A new start re-asserts cpu_reset first.
//  - Throughput: 1 byte/cycle sustained; mem_we never asserted on two adjacent cycles.
// STRUCTURE
//  - Shared header loader_defs.vh: state encodings, HDR_BYTES=2, CSUM_OK=8'h00.
//  - Sub-module word_assembler: 2-bit byte index, 32-bit LE shift/fill, word_valid pulse.
//    Cleared on reset/start.
//  - Top: FSM, word counter, N register, checksum accumulator, output registers.
// TESTING
//  1. Reset held 3 cycles -> all outputs at reset values; cpu_reset=1; in_ready=0.
//  2. start; bytes 02 00 93 00 50 00 13 01 F0 FF 18 ->
//     mem_we at addr 0 = 0x00500093 and at addr 1 = 0xFFF00113;
//     done=1, cpu_reset=0, words_loaded=2.
//  3. Same frame with trailer 19 -> both words written, error=1, done=0, cpu_reset=1.
//  4. Frame 00 00 00 -> no mem_we, done=1, words_loaded=0, cpu_reset=0.
//  5. Header 01 01 (N=257, ADDR_WIDTH=8) -> ERROR after HDR1, in_ready=0, no mem_we.
//     Header 00 01 (N=256) is accepted.
//  6. Random in_valid gaps on frame 2 -> identical writes.
//     reset after 5 data bytes -> exactly one write, then IDLE, cpu_reset=1.
//     start pulsed mid-load -> ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the framed-byte-stream instruction memory loader.
// Loader FSM states and checksum constant.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [7:0] CSUM_OK = 8'h00;

    function automatic logic rx_state(state_e s);
        return (s == S_HDR0) || (s == S_HDR1) ||
               (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words.
// word_valid_o pulses combinationally as the fourth byte is accepted.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [23:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            idx_q  <= '0;
            data_q <= '0;
        end else if (accept_i) begin
            idx_q  <= idx_q + 2'd1;
            data_q <= {byte_i, data_q[23:8]};
        end
    end

    assign word_valid_o = accept_i && (idx_q == 2'd3);
    assign word_o       = {byte_i, data_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into imem and holds the cpu in reset
// until a complete frame has been written with a valid checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    state_e state_q, state_d;

    logic [15:0]           n_q, n_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpur_q, cpur_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        accept;
    logic        start_ok;
    logic [15:0] n_full;
    logic        overflow;
    logic [7:0]  csum_next;
    logic        last_word;
    logic        enter_done;
    logic        enter_err;
    logic        word_valid;
    logic [31:0] word;

    assign in_ready  = rx_state(state_q);
    assign accept    = in_valid && in_ready;
    assign start_ok  = start && !in_ready;
    assign n_full    = {in_data, n_q[7:0]};
    assign overflow  = {1'b0, n_full} > CAPACITY;
    assign csum_next = csum_q + in_data;
    assign last_word = {1'b0, n_q} == (17'(cnt_q) + 17'd1);

    assign enter_done = (state_q == S_CSUM) && accept &&
                        (csum_next == CSUM_OK);
    assign enter_err  = accept &&
                        (((state_q == S_CSUM) && (csum_next != CSUM_OK)) ||
                         ((state_q == S_HDR1) && overflow));

    word_assembler u_asm (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (start_ok),
        .accept_i     (accept && (state_q == S_DATA)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR:
                if (start) state_d = S_HDR0;
            S_HDR0:
                if (accept) state_d = S_HDR1;
            S_HDR1:
                if (accept) begin
                    if (overflow)           state_d = S_ERROR;
                    else if (n_full == '0)  state_d = S_CSUM;
                    else                    state_d = S_DATA;
                end
            S_DATA:
                if (word_valid && last_word) state_d = S_CSUM;
            S_CSUM:
                if (accept) state_d = enter_done ? S_DONE : S_ERROR;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; the new start wins over held flags.
    always_comb begin
        n_d     = n_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cpur_d  = cpur_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start_ok) begin
            n_d    = '0;
            csum_d = '0;
            cnt_d  = '0;
            cpur_d = 1'b1;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (accept) begin
            csum_d = csum_next;
            if (state_q == S_HDR0) n_d[7:0]  = in_data;
            if (state_q == S_HDR1) n_d[15:8] = in_data;
        end
        if (word_valid) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_WIDTH-1:0];
            wdata_d = word;
            cnt_d   = cnt_q + 1'b1;
        end
        if (enter_done) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            cpur_d = 1'b0;
        end
        if (enter_err) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q     <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cpur_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            n_q     <= n_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cpur_q  <= cpur_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_reset    = cpur_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a frame-level reference model
// and a per-cycle write scoreboard.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    wr_t        log_q[$];
    wr_t        exp_w;
    logic [7:0] frame[$];
    bit         mon_en = 1'b0;
    bit         prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write must match the next one the model predicted.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (in_ready !== busy) begin
                errors++;
                $display("FAIL ready_vs_busy: in_ready=%b busy=%b",
                         in_ready, busy);
            end
            if (mem_we === 1'b1) begin
                log_q.push_back({mem_addr, mem_wdata});
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL adjacent_we: got two strobes, expected one");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                             mem_addr, mem_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== exp_w) begin
                        errors++;
                        $display("FAIL write: got %0h/%08h expected %0h/%08h",
                                 mem_addr, mem_wdata, exp_w.a, exp_w.d);
                    end
                end
            end
            prev_we = (mem_we === 1'b1);
        end
    end

    task automatic model(output bit d, output bit e, output int w,
                         output int c);
        int         n;
        logic [7:0] s;
        wr_t        x;
        n = int'(frame[0]) | (int'(frame[1]) << 8);
        if (n > (1 << AW)) begin
            d = 1'b0; e = 1'b1; w = 0; c = 2;
        end else begin
            s = 8'h00;
            for (int k = 0; k < 3 + 4 * n; k++) s = s + frame[k];
            for (int i = 0; i < n; i++) begin
                x.a = AW'(i);
                x.d = {frame[5 + 4 * i], frame[4 + 4 * i],
                       frame[3 + 4 * i], frame[2 + 4 * i]};
                exp_q.push_back(x);
            end
            c = 3 + 4 * n;
            w = n;
            d = (s == 8'h00);
            e = !d;
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_bytes(input int cnt, input bit gaps,
                              input int start_at);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit acc;
        bit pulsed = 1'b0;
        while (idx < cnt && cyc < 6000) begin
            @(negedge clk);
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = frame[idx];
            start    = (idx == start_at) && v && !pulsed;
            if (start) pulsed = 1'b1;
            #1 acc = v && in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk("bytes_accepted", idx, cnt);
    endtask

    task automatic check_final(input bit d, input bit e, input int w);
        chk("done", done, d);
        chk("error", error, e);
        chk("cpu_reset", cpu_reset, !d);
        chk("busy", busy, 0);
        chk("in_ready", in_ready, 0);
        chk("words_loaded", words_loaded, w);
        chk("writes_pending", exp_q.size(), 0);
    endtask

    task automatic run_frame(input bit gaps, input int start_at);
        bit d, e;
        int w, c;
        model(d, e, w, c);
        log_q.delete();
        do_start();
        send_bytes(c, gaps, start_at);
        repeat (3) @(negedge clk);
        check_final(d, e, w);
    endtask

    task automatic load_frame2(input logic [7:0] trailer);
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                  8'h13, 8'h01, 8'hF0, 8'hFF, trailer};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] s;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        @(negedge clk) reset = 1'b0;
        mon_en = 1'b1;

        load_frame2(8'h18);
        run_frame(1'b0, -1);
        chk("lit_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("lit_w0", log_q[0], {8'd0, 32'h00500093});
            chk("lit_w1", log_q[1], {8'd1, 32'hFFF00113});
        end
        chk("lit_done", done, 1);
        chk("lit_words", words_loaded, 2);

        load_frame2(8'h19);
        run_frame(1'b0, -1);
        chk("bad_csum_writes", log_q.size(), 2);
        chk("lit_error", error, 1);
        chk("lit_cpu_reset_err", cpu_reset, 1);

        frame = '{8'h00, 8'h00, 8'h00};
        run_frame(1'b0, -1);
        chk("empty_writes", log_q.size(), 0);
        chk("lit_empty_done", done, 1);

        frame = '{8'h01, 8'h01};
        run_frame(1'b0, -1);
        chk("ovf_writes", log_q.size(), 0);
        chk("lit_ovf_error", error, 1);

        frame = '{8'h00, 8'h01};
        s = 8'h01;
        for (int k = 0; k < 1024; k++) begin
            frame.push_back(8'(k * 7 + 3));
            s = s + 8'(k * 7 + 3);
        end
        frame.push_back(8'h00 - s);
        run_frame(1'b0, -1);
        chk("full_writes", log_q.size(), 256);
        chk("lit_full_words", words_loaded, 256);

        load_frame2(8'h18);
        run_frame(1'b1, -1);
        chk("gap_writes", log_q.size(), 2);

        load_frame2(8'h18);
        run_frame(1'b0, 5);
        chk("midstart_writes", log_q.size(), 2);

        load_frame2(8'h18);
        log_q.delete();
        exp_w.a = '0;
        exp_w.d = 32'h00500093;
        exp_q.push_back(exp_w);
        do_start();
        send_bytes(7, 1'b0, -1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_words", words_loaded, 0);
        chk("mid_rst_we", mem_we, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_writes", log_q.size(), 1);
        chk("mid_rst_pending", exp_q.size(), 0);

        load_frame2(8'h18);
        run_frame(1'b0, -1);
        chk("after_rst_writes", log_q.size(), 2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
